mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-bus controller directly downstream of the CPU control FSM.
- Consumes the FSM's mem_cmd (NONE/READ/WRITE) together with the address and write data from the datapath.
- Routes each access to the on-chip RAM, the LED output register or the switch input port, inserting a programmable number of wait states.
- Returns read data and a one-cycle mem_ready completion pulse. The FSM holds its memory state until it sees mem_ready.

Parameters:
- ADDR_W, 9, width of the CPU memory address.
- DATA_W, 16, data word width.
- RAM_AW, 8, RAM address width; RAM occupies addresses 0 to 2^RAM_AW-1.
- WAIT_STATES, 1, ACCESS cycles per transaction; legal range 1 to 15.
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch port address.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_cmd  in  2  00 NONE, 01 READ, 10 WRITE, 11 reserved.
- mem_addr  in  ADDR_W  access address.
- write_data  in  DATA_W  store data.
- read_data  out  DATA_W  load result, registered.
- mem_ready  out  1  one-cycle completion pulse.
- ram_addr  out  RAM_AW  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after ram_addr.
- sw  in  8  asynchronous switch inputs.
- led  out  8  LED register.
- bus_err  out  1  sticky access-error flag; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous), effective immediately:
  - state=IDLE.
  - read_data, led, ram_addr, ram_din = 0.
  - ram_we, mem_ready, bus_err = 0.
  - Wait counter and switch synchronizer cleared.
  - A transaction in flight is abandoned; no partial RAM or LED write occurs after reset asserts.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On a clock edge with mem_cmd READ or WRITE, capture cmd, mem_addr, write_data and the decoded target, load the wait counter with WAIT_STATES, and go to ACCESS.
  - NONE and 11 are ignored; the block stays in IDLE.
- Address decode of the captured address:
  - RAM if addr < 2^RAM_AW.
  - LED if addr == LED_ADDR.
  - SW if addr == SW_ADDR.
  - Otherwise UNMAPPED.
- ACCESS:
  - ram_addr = captured addr[RAM_AW-1:0]; ram_din = captured data.
  - ram_we=1 only in the final ACCESS cycle (counter==1) of a RAM write.
  - Counter decrements each cycle; at counter==1 go to DONE.
- DONE (exactly one cycle):
  - mem_ready=1.
  - RAM read: read_data <= ram_dout.
  - SW read: read_data <= {8'h00, sw_sync}.
  - UNMAPPED read: read_data <= 0.
  - LED write: led <= write_data[7:0].
  - Writes to SW or UNMAPPED are dropped.
  - Next state is IDLE unconditionally.
- Latency: command sampled at edge 0 → ACCESS occupies cycles 1..WAIT_STATES → mem_ready in cycle WAIT_STATES+1 → IDLE in cycle WAIT_STATES+2, earliest edge to accept the next command.
- mem_cmd, mem_addr and write_data changes after capture are ignored until the block returns to IDLE.
- read_data holds its last value between reads; writes never alter it.
- sw passes through a 2-flop synchronizer; sw_sync is what is returned.
- led changes only in DONE of an LED write.
- ram_we never asserts for non-RAM targets or for reads.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined:
  - bus_err is set in DONE of any UNMAPPED access, any write to SW_ADDR, or any read of LED_ADDR.
  - bus_err is also set if mem_cmd==11 is sampled in IDLE.
  - bus_err is sticky and cleared only by reset.
  - A read of LED_ADDR returns {8'h00, led}.
- Undefined:
  - bus_err is tied 0.
  - A read of LED_ADDR returns 0, as for UNMAPPED.

Test Plan:
- Reset, then WAIT_STATES=1: WRITE addr 9'h005 data 16'hABCD → ram_we=1 for exactly cycle 1 with ram_addr=8'h05; mem_ready in cycle 2. Then READ 9'h005 → read_data=16'hABCD at the mem_ready edge.
- WAIT_STATES=3: READ 9'h010 → mem_ready exactly in cycle 4. mem_cmd dropped to NONE in cycle 1 → transaction still completes. A new READ is accepted only from cycle 5.
- WRITE 9'h100 data 16'h12A5 → led=8'hA5 after DONE, ram_we never 1. sw=8'h3C held, READ 9'h140 → read_data=16'h003C.
- Assert reset during ACCESS of a RAM write with WAIT_STATES=3 (cycle 2) → ram_we stays 0, state IDLE, led=0, read_data=0, no mem_ready.
- With MEM_BUS_ERR_EN: READ 9'h1FF → read_data=0, bus_err=1 and it stays 1 across later good accesses until reset. Without the macro the same stimulus gives bus_err=0.
- mem_cmd=11 in IDLE → no state change, no mem_ready. bus_err=1 only when MEM_BUS_ERR_EN is defined.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: routes CPU mem_cmd accesses to RAM, the LED register or the switch port with WAIT_STATES access cycles.
// Define MEM_BUS_ERR_EN to enable the sticky bus_err flag and LED read-back.
module mem_bus_ctrl #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 16,
    parameter int                RAM_AW      = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR     = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    output logic              bus_err
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {TGT_RAM, TGT_LED, TGT_SW, TGT_UNMAPPED} target_t;

    state_t            state;
    state_t            state_next;
    target_t           target_dec;
    target_t           target_q;
    logic              is_write_q;
    logic [RAM_AW-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        wait_cnt;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic              cmd_valid;

    assign cmd_valid = (mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE);

    always_comb begin
        target_dec = TGT_UNMAPPED;
        if ((mem_addr >> RAM_AW) == '0)
            target_dec = TGT_RAM;
        else if (mem_addr == LED_ADDR)
            target_dec = TGT_LED;
        else if (mem_addr == SW_ADDR)
            target_dec = TGT_SW;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ram_we is confined to the last ACCESS cycle so a reset mid-access never leaves a partial write
    always_comb begin
        state_next = state;
        mem_ready  = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid)
                    state_next = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt == 4'd1) begin
                    state_next = DONE;
                    ram_we     = is_write_q && (target_q == TGT_RAM);
                end
            end
            DONE: begin
                mem_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_addr = addr_q;
    assign ram_din  = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q   <= TGT_RAM;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            read_data  <= '0;
            led        <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target_q   <= target_dec;
                        is_write_q <= (mem_cmd == CMD_WRITE);
                        addr_q     <= mem_addr[RAM_AW-1:0];
                        data_q     <= write_data;
                        wait_cnt   <= WAIT_INIT;
                    end
                end
                ACCESS: wait_cnt <= wait_cnt - 4'd1;
                DONE: begin
                    if (!is_write_q) begin
                        case (target_q)
                            TGT_RAM: read_data <= ram_dout;
                            TGT_SW:  read_data <= DATA_W'(sw_sync);
`ifdef MEM_BUS_ERR_EN
                            TGT_LED: read_data <= DATA_W'(led);
`endif
                            default: read_data <= '0;
                        endcase
                    end else if (target_q == TGT_LED) begin
                        led <= data_q[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BUS_ERR_EN
    // Sticky: only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_err <= 1'b0;
        else if ((state == IDLE && mem_cmd == 2'b11) ||
                 (state == DONE && ((target_q == TGT_UNMAPPED) ||
                                    (is_write_q && target_q == TGT_SW) ||
                                    (!is_write_q && target_q == TGT_LED))))
            bus_err <= 1'b1;
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: two instances (WAIT_STATES=1 and 3) driven by directed vectors.
// Expectations depend on whether MEM_BUS_ERR_EN is defined.
module tb_mem_bus_ctrl;

    typedef struct packed {
        logic [15:0] rd;
        logic [7:0]  led;
        logic        err;
    } exp_t;

`ifdef MEM_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [2];
    logic [1:0]  mem_cmd    [2];
    logic [8:0]  mem_addr   [2];
    logic [15:0] write_data [2];
    logic [15:0] read_data  [2];
    logic        mem_ready  [2];
    logic [7:0]  ram_addr   [2];
    logic [15:0] ram_din    [2];
    logic        ram_we     [2];
    logic [15:0] ram_dout   [2];
    logic [7:0]  sw         [2];
    logic [7:0]  led        [2];
    logic        bus_err    [2];

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    exp_t q0[$];
    exp_t q1[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [15:0] last_rd [2];
    logic [7:0]  led_m   [2];
    logic        err_m   [2];

    mem_bus_ctrl #(.WAIT_STATES(1)) dut0 (
        .clk(clk), .reset(reset[0]), .mem_cmd(mem_cmd[0]), .mem_addr(mem_addr[0]),
        .write_data(write_data[0]), .read_data(read_data[0]), .mem_ready(mem_ready[0]),
        .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_we(ram_we[0]),
        .ram_dout(ram_dout[0]), .sw(sw[0]), .led(led[0]), .bus_err(bus_err[0])
    );

    mem_bus_ctrl #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset[1]), .mem_cmd(mem_cmd[1]), .mem_addr(mem_addr[1]),
        .write_data(write_data[1]), .read_data(read_data[1]), .mem_ready(mem_ready[1]),
        .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_we(ram_we[1]),
        .ram_dout(ram_dout[1]), .sw(sw[1]), .led(led[1]), .bus_err(bus_err[1])
    );

    // Synchronous single-port RAM models, read-before-write
    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_addr[0]] <= ram_din[0];
        ram_dout[0] <= mem0[ram_addr[0]];
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_din[1];
        ram_dout[1] <= mem1[ram_addr[1]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Update the reference model for one transaction and queue what the monitor should see after DONE
    task automatic predict(input int idx, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        bit   is_wr;
        bit   unmapped;
        is_wr    = (cmd == WRITE);
        unmapped = (addr >= 9'h100) && (addr != 9'h100) && (addr != 9'h140);
        if (!is_wr)
            last_rd[idx] = exp_rd;
        else if (addr == 9'h100)
            led_m[idx] = wd[7:0];
        if (ERR_EN && (unmapped || (is_wr && addr == 9'h140) || (!is_wr && addr == 9'h100)))
            err_m[idx] = 1'b1;
        e.rd  = last_rd[idx];
        e.led = led_m[idx];
        e.err = err_m[idx];
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Called at a negedge with the instance in IDLE; returns at a negedge in IDLE
    task automatic applyStimulus(input int idx, input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wd, input logic [15:0] exp_rd,
                                 input int exp_lat, input bit drop);
        int k;
        bit seen;
        bit exp_we;
        predict(idx, cmd, addr, wd, exp_rd);
        mem_cmd[idx]    = cmd;
        mem_addr[idx]   = addr;
        write_data[idx] = wd;
        @(posedge clk);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (drop && k == 1) mem_cmd[idx] = NONE;
            exp_we = (cmd == WRITE) && (addr < 9'h100) && (k == exp_lat - 1);
            checkOutput("ram_we", 32'(ram_we[idx]), 32'(exp_we));
            if (exp_we) checkOutput("ram_addr", 32'(ram_addr[idx]), 32'(addr[7:0]));
            if (mem_ready[idx]) seen = 1'b1;
        end
        checkOutput("latency", k, exp_lat);
        mem_cmd[idx] = NONE;
        @(negedge clk);
    endtask

    task automatic monitor(input int idx);
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (mem_ready[idx]) begin
                have = 1'b0;
                if (idx == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (idx == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checkOutput("unexpected_mem_ready", 32'(idx), 32'hFFFF_FFFF);
                end else begin
                    @(posedge clk);
                    #1;
                    checkOutput("read_data", 32'(read_data[idx]), 32'(e.rd));
                    checkOutput("led", 32'(led[idx]), 32'(e.led));
                    checkOutput("bus_err", 32'(bus_err[idx]), 32'(e.err));
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            reset[i]      = 1'b0;
            mem_cmd[i]    = NONE;
            mem_addr[i]   = '0;
            write_data[i] = '0;
            last_rd[i]    = '0;
            led_m[i]      = '0;
            err_m[i]      = 1'b0;
        end
        sw[0] = 8'h00;
        sw[1] = 8'h3C;

        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_read_data", 32'(read_data[i]), 32'h0);
            checkOutput("rst_led", 32'(led[i]), 32'h0);
            checkOutput("rst_mem_ready", 32'(mem_ready[i]), 32'h0);
            checkOutput("rst_ram_we", 32'(ram_we[i]), 32'h0);
            checkOutput("rst_ram_addr", 32'(ram_addr[i]), 32'h0);
            checkOutput("rst_bus_err", 32'(bus_err[i]), 32'h0);
        end
        repeat (3) @(negedge clk);
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clk);

        // WAIT_STATES=1: RAM write then read-back, then reserved command
        applyStimulus(0, WRITE, 9'h005, 16'hABCD, 16'h0000, 2, 1'b0);
        applyStimulus(0, READ,  9'h005, 16'h0000, 16'hABCD, 2, 1'b0);

        mem_cmd[0]  = 2'b11;
        mem_addr[0] = 9'h005;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("rsv_mem_ready", 32'(mem_ready[0]), 32'h0);
            checkOutput("rsv_ram_we", 32'(ram_we[0]), 32'h0);
        end
        mem_cmd[0] = NONE;
        @(negedge clk);
        checkOutput("rsv_bus_err", 32'(bus_err[0]), 32'(ERR_EN));
        err_m[0] = ERR_EN;
        applyStimulus(0, READ, 9'h005, 16'h0000, 16'hABCD, 2, 1'b0);

        // WAIT_STATES=3: RAM traffic, command dropped after capture
        applyStimulus(1, WRITE, 9'h010, 16'h5A5A, 16'h0000, 4, 1'b0);
        applyStimulus(1, WRITE, 9'h020, 16'h1234, 16'h0000, 4, 1'b0);
        applyStimulus(1, READ,  9'h010, 16'h0000, 16'h5A5A, 4, 1'b1);

        // Held READ with address changed mid-flight: second capture only at the IDLE edge
        predict(1, READ, 9'h010, 16'h0000, 16'h5A5A);
        predict(1, READ, 9'h020, 16'h0000, 16'h1234);
        mem_cmd[1]  = READ;
        mem_addr[1] = 9'h010;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) mem_addr[1] = 9'h020;
            checkOutput("b2b_mem_ready", 32'(mem_ready[1]), 32'(k == 4 || k == 9));
        end
        mem_cmd[1] = NONE;
        @(negedge clk);

        // Peripherals and error cases
        applyStimulus(1, WRITE, 9'h100, 16'h12A5, 16'h0000, 4, 1'b0);
        applyStimulus(1, READ,  9'h140, 16'h0000, 16'h003C, 4, 1'b0);
        applyStimulus(1, READ,  9'h1FF, 16'h0000, 16'h0000, 4, 1'b0);
        applyStimulus(1, READ,  9'h100, 16'h0000, ERR_EN ? 16'h00A5 : 16'h0000, 4, 1'b0);
        applyStimulus(1, READ,  9'h010, 16'h0000, 16'h5A5A, 4, 1'b0);

        // Reset in the middle of a RAM write
        mem_cmd[1]    = WRITE;
        mem_addr[1]   = 9'h030;
        write_data[1] = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_pre_ram_we", 32'(ram_we[1]), 32'h0);
        @(negedge clk);
        reset[1]   = 1'b0;
        mem_cmd[1] = NONE;
        #1;
        checkOutput("abort_ram_we", 32'(ram_we[1]), 32'h0);
        checkOutput("abort_mem_ready", 32'(mem_ready[1]), 32'h0);
        checkOutput("abort_read_data", 32'(read_data[1]), 32'h0);
        checkOutput("abort_led", 32'(led[1]), 32'h0);
        checkOutput("abort_bus_err", 32'(bus_err[1]), 32'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_hold_ram_we", 32'(ram_we[1]), 32'h0);
            checkOutput("abort_hold_mem_ready", 32'(mem_ready[1]), 32'h0);
        end
        reset[1]   = 1'b1;
        last_rd[1] = '0;
        led_m[1]   = '0;
        err_m[1]   = 1'b0;
        @(negedge clk);
        applyStimulus(1, READ, 9'h030, 16'h0000, 16'h0000, 4, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
